// File: rtl/data_mem_ctrl_if.sv
// Bus between the CPU memory stage, the load/store sequencer and the 8-bit data RAM.
// master = CPU and RAM side, slave = sequencer.
interface data_mem_ctrl_if #(
  parameter int unsigned AddrW = 11
);
  logic             req;
  logic             wr;
  logic [2:0]       funct3;
  logic [AddrW-1:0] addr;
  logic [31:0]      wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      rdata;
  logic             ram_re;
  logic [AddrW-1:0] ram_raddr;
  logic [7:0]       ram_rdata;
  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  logic [7:0]       ram_wdata;

  modport master (
    output req, wr, funct3, addr, wdata, ram_rdata,
    input  busy, done, err, rdata, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
  );

  modport slave (
    input  req, wr, funct3, addr, wdata, ram_rdata,
    output busy, done, err, rdata, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer: splits RISC-V byte/half/word accesses into little-endian byte
// accesses on an 8-bit RAM port and sign/zero-extends load results.
module data_mem_ctrl #(
  parameter int unsigned AddrW = 11
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRdIssue = 2'd1;
  localparam logic [1:0] StRdCapt  = 2'd2;
  localparam logic [1:0] StWrByte  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       last_idx;
  logic [2:0]       f3_q;
  logic [AddrW-1:0] addr_q;
  logic [31:0]      wdata_q, rbuf_q, rdata_q;
  logic [31:0]      word, ext;
  logic             done_q, done_d, err_q, err_d;
  logic             legal, start, accept, capture, is_last;

  // Top two address bits both set means 1536 or above.
  always_comb begin
    legal = 1'b1;
    if (bus.addr[AddrW-1 -: 2] == 2'b11) legal = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   if (bus.addr[0]) legal = 1'b0;
      2'b10:   if (bus.addr[1:0] != 2'b00) legal = 1'b0;
      2'b11:   legal = 1'b0;
      default: ;
    endcase
    if (bus.funct3[2] && (bus.wr || bus.funct3[1])) legal = 1'b0;
  end

  assign start    = (state_q == StIdle) && bus.req;
  assign accept   = start && legal;
  assign last_idx = {f3_q[1], f3_q[1] | f3_q[0]};
  assign is_last  = (cnt_q == last_idx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = bus.wr ? StWrByte : StRdIssue;
          cnt_d   = 2'd0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      StRdIssue: state_d = StRdCapt;
      StRdCapt: begin
        capture = 1'b1;
        if (is_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = StRdIssue;
        end
      end
      StWrByte: begin
        if (is_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Merge the byte arriving this cycle so the final byte reaches RDATA with DONE.
  always_comb begin
    word = rbuf_q;
    word[{cnt_q, 3'b000} +: 8] = bus.ram_rdata;
    case (f3_q)
      3'b000:  ext = {{24{word[7]}}, word[7:0]};
      3'b001:  ext = {{16{word[15]}}, word[15:0]};
      3'b100:  ext = {24'h000000, word[7:0]};
      3'b101:  ext = {16'h0000, word[15:0]};
      default: ext = word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rbuf_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (capture) rbuf_q <= word;
      if (capture && is_last) rdata_q <= ext;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_re    = (state_q == StRdIssue) || (state_q == StRdCapt);
  assign bus.ram_raddr = addr_q + AddrW'(cnt_q);
  assign bus.ram_we    = (state_q == StWrByte);
  assign bus.ram_waddr = addr_q + AddrW'(cnt_q);
  assign bus.ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl against a byte-array memory model.
module tb_data_mem_ctrl;
  logic clk;
  logic rst_n;
  data_mem_ctrl_if #(.AddrW(11)) bus ();

  data_mem_ctrl #(.AddrW(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM seen by the DUT: combinational read, synchronous write.
  logic [7:0] ram [0:1535] = '{default: 8'h00};
  always @(posedge clk) if (bus.ram_we && bus.ram_waddr < 11'd1536) ram[bus.ram_waddr] <= bus.ram_wdata;
  assign bus.ram_rdata = (bus.ram_raddr < 11'd1536) ? ram[bus.ram_raddr] : 8'h00;

  // Reference contents of memory, maintained from the architectural effect of each store.
  logic [7:0]  ref_mem [0:1535] = '{default: 8'h00};
  logic [31:0] exp_rdata;
  int          errors = 0;
  int          checks = 0;

  int          done_cyc, err_cyc, re_cnt, we_cnt;
  bit          both_hi;
  logic        busy_tr [0:31];
  logic [10:0] re_q[$];
  logic [10:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];

  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic w, input logic [2:0] f, input int a);
    if (a >= 1536) return 0;
    if (w && f > 3'd2) return 0;
    if (!w && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 0;
    if (a % nbytes(f) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input int a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(f); i++) v = v | (32'(ref_mem[a+i]) << (8 * i));
    if (f == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    if (f == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic int exp_lat(input logic w, input logic [2:0] f);
    return w ? nbytes(f) + 1 : 2 * nbytes(f) + 1;
  endfunction

  task automatic model_store(input logic [2:0] f, input int a, input logic [31:0] d);
    for (int i = 0; i < nbytes(f); i++) ref_mem[a+i] = d[8*i +: 8];
  endtask

  // Issues one request in cycle 0 and records what the DUT does until DONE/ERR or timeout.
  // pulse_cyc > 0 raises a stray store request for one cycle at that cycle number.
  task automatic run_req(input logic w, input logic [2:0] f, input logic [10:0] a,
                         input logic [31:0] d, input int pulse_cyc);
    done_cyc = -1; err_cyc = -1; re_cnt = 0; we_cnt = 0; both_hi = 0;
    re_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
    for (int i = 0; i < 32; i++) busy_tr[i] = 1'bx;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = w; bus.funct3 = f; bus.addr = a; bus.wdata = d;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.req = (c == pulse_cyc);
        if (c == pulse_cyc) begin
          bus.wr = 1'b1; bus.funct3 = 3'b010; bus.addr = 11'h100; bus.wdata = $urandom;
        end
      end
      @(negedge clk);
      busy_tr[c] = bus.busy;
      if (bus.ram_re) begin re_cnt++; re_q.push_back(bus.ram_raddr); end
      if (bus.ram_we) begin
        we_cnt++; wa_q.push_back(bus.ram_waddr); wd_q.push_back(bus.ram_wdata); wc_q.push_back(c);
      end
      if (bus.done && bus.err) both_hi = 1;
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (bus.err && err_cyc < 0) err_cyc = c;
      if (c > 0 && (bus.done || bus.err)) break;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.ram_re !== 1'b0 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL rst_en: got re=%b we=%b want 0 0", bus.ram_re, bus.ram_we);
    end
    checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'd0;
  endtask

  task automatic test_sw_lw();
    int bad;
    run_req(1'b1, 3'b010, 11'h000, 32'hDEADBEEF, 0);
    model_store(3'b010, 0, 32'hDEADBEEF);
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL sw_done: got %0d want 5", done_cyc); end
    checks++; if (we_cnt !== 4) begin errors++; $display("FAIL sw_we_cnt: got %0d want 4", we_cnt); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wc_q[i] != i + 1 || wa_q[i] !== 11'(i) || wd_q[i] !== ref_mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sw_bytes: got %0d bad want 0", bad); end
    bad = 0;
    for (int c = 0; c <= 5; c++) if (busy_tr[c] !== (c >= 1 && c <= 4)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sw_busy: got %0d bad want 0", bad); end

    run_req(1'b0, 3'b010, 11'h000, 32'h0, 3);
    exp_rdata = 32'hDEADBEEF;
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL lw_done: got %0d want 9", done_cyc); end
    checks++; if (bus.rdata !== exp_rdata) begin
      errors++; $display("FAIL lw_rdata: got %h want %h", bus.rdata, exp_rdata);
    end
    checks++; if (we_cnt !== 0 || re_cnt !== 8) begin
      errors++; $display("FAIL lw_en: got we=%0d re=%0d want 0 8", we_cnt, re_cnt);
    end
    bad = 0;
    for (int i = 0; i < re_q.size(); i++) if (re_q[i] !== 11'(i / 2)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL lw_raddr: got %0d bad want 0", bad); end
  endtask

  task automatic test_extension();
    logic [2:0]  tf [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [10:0] ta [5] = '{11'h003, 11'h003, 11'h002, 11'h002, 11'h000};
    logic [31:0] tv [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
    for (int k = 0; k < 5; k++) begin
      run_req(1'b0, tf[k], ta[k], 32'h0, 0);
      exp_rdata = tv[k];
      checks++; if (bus.rdata !== tv[k]) begin
        errors++; $display("FAIL ext_%0d: got %h want %h", k, bus.rdata, tv[k]);
      end
      checks++; if (done_cyc !== exp_lat(1'b0, tf[k])) begin
        errors++; $display("FAIL ext_lat_%0d: got %0d want %0d", k, done_cyc, exp_lat(1'b0, tf[k]));
      end
    end
  endtask

  task automatic test_range();
    run_req(1'b1, 3'b010, 11'h5FC, 32'h01234567, 0);
    model_store(3'b010, 'h5FC, 32'h01234567);
    run_req(1'b0, 3'b010, 11'h5FC, 32'h0, 0);
    exp_rdata = 32'h01234567;
    checks++; if (bus.rdata !== exp_rdata) begin
      errors++; $display("FAIL top_rdata: got %h want %h", bus.rdata, exp_rdata);
    end
    run_req(1'b0, 3'b010, 11'h600, 32'h0, 0);
    checks++; if (err_cyc !== 1 || done_cyc !== -1) begin
      errors++; $display("FAIL oor_err: got err=%0d done=%0d want 1 -1", err_cyc, done_cyc);
    end
    checks++; if (re_cnt !== 0 || we_cnt !== 0 || busy_tr[1] !== 1'b0) begin
      errors++; $display("FAIL oor_ram: got re=%0d we=%0d busy=%b want 0 0 0", re_cnt, we_cnt,
                         busy_tr[1]);
    end
    checks++; if (bus.rdata !== exp_rdata) begin
      errors++; $display("FAIL oor_rdata: got %h want %h", bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_illegal();
    logic        tw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  tf [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [10:0] ta [4] = '{11'h002, 11'h001, 11'h000, 11'h000};
    for (int k = 0; k < 4; k++) begin
      run_req(tw[k], tf[k], ta[k], 32'hFFFF_FFFF, 0);
      checks++; if (err_cyc !== 1 || done_cyc !== -1 || both_hi) begin
        errors++; $display("FAIL ill_%0d_err: got err=%0d done=%0d want 1 -1", k, err_cyc, done_cyc);
      end
      checks++; if (re_cnt !== 0 || we_cnt !== 0 || busy_tr[1] !== 1'b0) begin
        errors++; $display("FAIL ill_%0d_ram: got re=%0d we=%0d want 0 0", k, re_cnt, we_cnt);
      end
      checks++; if (bus.rdata !== exp_rdata) begin
        errors++; $display("FAIL ill_%0d_rdata: got %h want %h", k, bus.rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sb_done = -1, lb_done = -1, we_n = 0, re_n = 0;
    bit any_err = 0;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = 1'b1; bus.funct3 = 3'b000; bus.addr = 11'h010; bus.wdata = 32'h5A5A5AAA;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (sb_done >= 0 && c == sb_done + 1) bus.req = 1'b0;
      end
      @(negedge clk);
      if (bus.ram_we) we_n++;
      if (bus.ram_re) re_n++;
      if (bus.err) any_err = 1;
      if (bus.done) begin
        if (sb_done < 0) begin
          sb_done = c; bus.wr = 1'b0; bus.funct3 = 3'b100;
        end else begin
          lb_done = c; break;
        end
      end
    end
    ref_mem['h10] = 8'hAA;
    exp_rdata = 32'h000000AA;
    checks++; if (sb_done !== 2 || lb_done !== 5) begin
      errors++; $display("FAIL b2b_done: got %0d,%0d want 2,5", sb_done, lb_done);
    end
    checks++; if (bus.rdata !== exp_rdata) begin
      errors++; $display("FAIL b2b_rdata: got %h want %h", bus.rdata, exp_rdata);
    end
    checks++; if (we_n !== 1 || re_n !== 2 || any_err) begin
      errors++; $display("FAIL b2b_ram: got we=%0d re=%0d err=%b want 1 2 0", we_n, re_n, any_err);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    @(posedge clk); #1;
    bus.req = 1'b1; bus.wr = 1'b1; bus.funct3 = 3'b010; bus.addr = 11'h020; bus.wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.err, bus.ram_re, bus.ram_we} !== 5'b0) begin
      errors++; $display("FAIL mid_ctl: got %b want 00000",
                         {bus.busy, bus.done, bus.err, bus.ram_re, bus.ram_we});
    end
    checks++; if (bus.rdata !== 32'd0 || bus.ram_raddr !== 11'd0 || bus.ram_waddr !== 11'd0 ||
                  bus.ram_wdata !== 8'd0) begin
      errors++; $display("FAIL mid_data: got rdata=%h ra=%h wa=%h wd=%h want 0", bus.rdata,
                         bus.ram_raddr, bus.ram_waddr, bus.ram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.done) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("FAIL mid_nodone: got %0d want 0", dn); end
    ref_mem['h20] = 8'h44;
    run_req(1'b0, 3'b010, 11'h020, 32'h0, 0);
    exp_rdata = 32'h00000044;
    checks++; if (bus.rdata !== exp_rdata || done_cyc !== 9) begin
      errors++; $display("FAIL mid_lw: got %h@%0d want %h@9", bus.rdata, done_cyc, exp_rdata);
    end
  endtask

  task automatic test_random();
    logic        w;
    logic [2:0]  f;
    logic [10:0] a;
    logic [31:0] d;
    int          n, lat, bad;
    for (int it = 0; it < 60; it++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = 11'($urandom_range(0, 2047));
      d = $urandom;
      n = nbytes(f);
      if ($urandom_range(0, 3) != 0) a = a & ~11'(n - 1);
      if ($urandom_range(0, 3) != 0 && a >= 11'd1536) a = a - 11'd1024;
      run_req(w, f, a, d, 0);
      if (is_legal(w, f, int'(a))) begin
        lat = exp_lat(w, f);
        checks++; if (done_cyc !== lat || err_cyc !== -1) begin
          errors++; $display("FAIL rnd%0d_lat: got done=%0d err=%0d want %0d", it, done_cyc,
                             err_cyc, lat);
        end
        bad = 0;
        for (int c = 0; c <= lat && c < 31; c++) if (busy_tr[c] !== (c >= 1 && c < lat)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_busy: got %0d bad want 0", it, bad); end
        if (w) begin
          model_store(f, int'(a), d);
          bad = (we_cnt != n || re_cnt != 0) ? 1 : 0;
          for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== a + 11'(i) || wd_q[i] !== d[8*i +: 8]) bad++;
          checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_wr: got %0d bad want 0", it, bad); end
        end else begin
          exp_rdata = exp_load(f, int'(a));
          bad = (re_cnt != 2 * n || we_cnt != 0) ? 1 : 0;
          for (int i = 0; i < re_q.size(); i++) if (re_q[i] !== a + 11'(i / 2)) bad++;
          checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_rd: got %0d bad want 0", it, bad); end
        end
      end else begin
        checks++; if (err_cyc !== 1 || done_cyc !== -1 || re_cnt !== 0 || we_cnt !== 0) begin
          errors++; $display("FAIL rnd%0d_ill: got err=%0d done=%0d re=%0d we=%0d want 1 -1 0 0",
                             it, err_cyc, done_cyc, re_cnt, we_cnt);
        end
      end
      checks++; if (bus.rdata !== exp_rdata || both_hi) begin
        errors++; $display("FAIL rnd%0d_rdata: got %h want %h", it, bus.rdata, exp_rdata);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.funct3 = 3'd0; bus.addr = 11'd0; bus.wdata = 32'd0;
    test_reset();
    test_sw_lw();
    test_extension();
    test_range();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
